// File: rtl/keypad_entry.sv
// rtl/keypad_entry.sv - 4x4 keypad scanner with frame debounce, hex entry register and 7-seg mux
// Keys are judged per full scan frame so ghosting and multi-key chords are rejected as MULTI.
module keypad_entry #(
  parameter int SCAN_DIV       = 8,
  parameter int DEBOUNCE_SCANS = 3,
  parameter int DIGITS         = 4,
  parameter int REFRESH_DIV    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic [3:0]          col,
  input  logic [3:0]          row,
  input  logic                clr,
  output logic                key_valid,
  output logic [3:0]          key_code,
  output logic [4*DIGITS-1:0] value,
  output logic [6:0]          seg,
  output logic [DIGITS-1:0]   an
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [SW-1:0] SCAN_LAST    = SW'(SCAN_DIV - 1);
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] DEB_TGT      = BW'(DEBOUNCE_SCANS);
  localparam logic [2:0]    DIGIT_LAST   = 3'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, RELEASE_CHK} state_t;

  function automatic logic [3:0] key_map(input logic [1:0] c, input logic [1:0] r);
    case ({c, r})
      4'h0: key_map = 4'h1;  4'h1: key_map = 4'h4;  4'h2: key_map = 4'h7;  4'h3: key_map = 4'h0;
      4'h4: key_map = 4'h2;  4'h5: key_map = 4'h5;  4'h6: key_map = 4'h8;  4'h7: key_map = 4'hF;
      4'h8: key_map = 4'h3;  4'h9: key_map = 4'h6;  4'hA: key_map = 4'h9;  4'hB: key_map = 4'hE;
      4'hC: key_map = 4'hA;  4'hD: key_map = 4'hB;  4'hE: key_map = 4'hC;  default: key_map = 4'hD;
    endcase
  endfunction

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b1000000;  4'h1: hex7 = 7'b1111001;  4'h2: hex7 = 7'b0100100;  4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;  4'h5: hex7 = 7'b0010010;  4'h6: hex7 = 7'b0000010;  4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;  4'h9: hex7 = 7'b0010000;  4'hA: hex7 = 7'b0001000;  4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;  4'hD: hex7 = 7'b0100001;  4'hE: hex7 = 7'b0000110;  default: hex7 = 7'b0001110;
    endcase
  endfunction

  logic [3:0]    row_s1, row_s2;
  logic [SW-1:0] scan_cnt;
  logic [1:0]    cidx;
  logic [1:0]    acc_n;
  logic [3:0]    acc_code;
  logic          sample_now, frame_end;
  logic [1:0]    hits, hit_row, f_n;
  logic [2:0]    sum;
  logic [3:0]    f_code;

  assign sample_now = (scan_cnt == SCAN_LAST);
  assign frame_end  = sample_now && (cidx == 2'd3);

  // f_n saturates at 2: 0 = NONE, 1 = ONE(f_code), 2 = MULTI
  always_comb begin
    hits    = 2'd0;
    hit_row = 2'd0;
    for (int r = 0; r < 4; r++) begin
      if (!row_s2[r]) begin
        if (hits != 2'd2) hits = hits + 2'd1;
        hit_row = 2'(r);
      end
    end
    sum    = {1'b0, acc_n} + {1'b0, hits};
    f_n    = (sum >= 3'd2) ? 2'd2 : sum[1:0];
    f_code = (hits == 2'd1) ? key_map(cidx, hit_row) : acc_code;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_s1   <= 4'hF;
      row_s2   <= 4'hF;
      scan_cnt <= '0;
      cidx     <= 2'd0;
      col      <= 4'b1110;
      acc_n    <= 2'd0;
      acc_code <= 4'h0;
    end else begin
      row_s1 <= row;
      row_s2 <= row_s1;
      if (sample_now) begin
        scan_cnt <= '0;
        cidx     <= cidx + 2'd1;
        col      <= {col[2:0], col[3]};
        acc_n    <= frame_end ? 2'd0 : f_n;
        acc_code <= frame_end ? 4'h0 : f_code;
      end else begin
        scan_cnt <= scan_cnt + SW'(1);
      end
    end
  end

  state_t                  state;
  logic [BW-1:0]           stab, stab_inc;
  logic [3:0]              cand;
  logic                    accept;
  logic [4*DIGITS+3:0]     shifted;

  always_comb begin
    stab_inc = stab + BW'(1);
    shifted  = {value, f_code};
    accept   = 1'b0;
    if (frame_end && f_n == 2'd1) begin
      if (state == IDLE)           accept = (DEB_TGT == BW'(1));
      else if (state == PRESS_CHK) accept = (f_code == cand) && (stab_inc == DEB_TGT);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      stab      <= '0;
      cand      <= 4'h0;
      key_valid <= 1'b0;
      key_code  <= 4'h0;
      value     <= '0;
    end else begin
      key_valid <= accept;
      if (accept) key_code <= f_code;
      if (clr)         value <= '0;
      else if (accept) value <= shifted[4*DIGITS-1:0];
      if (frame_end) begin
        case (state)
          IDLE:
            if (f_n == 2'd1) begin
              cand <= f_code;
              if (accept) begin state <= HELD;      stab <= '0;     end
              else        begin state <= PRESS_CHK; stab <= BW'(1); end
            end
          PRESS_CHK:
            if (f_n != 2'd1)           begin state <= IDLE; stab <= '0; end
            else if (f_code != cand)   begin cand <= f_code; stab <= BW'(1); end
            else if (accept)           begin state <= HELD; stab <= '0; end
            else                       stab <= stab_inc;
          HELD:
            if (f_n == 2'd0) begin
              if (DEB_TGT == BW'(1)) state <= IDLE;
              else begin state <= RELEASE_CHK; stab <= BW'(1); end
            end
          RELEASE_CHK:
            if (f_n != 2'd0)               begin state <= HELD; stab <= '0; end
            else if (stab_inc == DEB_TGT)  begin state <= IDLE; stab <= '0; end
            else                           stab <= stab_inc;
          default: state <= IDLE;
        endcase
      end
    end
  end

  logic [RW-1:0] ref_cnt;
  logic [2:0]    digit, digit_nx;
  logic [3:0]    nib;

  // an and seg are both driven from digit_nx so the lit digit and its pattern change together
  always_comb begin
    digit_nx = digit;
    if (ref_cnt == REFRESH_LAST) digit_nx = (digit == DIGIT_LAST) ? 3'd0 : digit + 3'd1;
    nib = 4'h0;
    for (int i = 0; i < DIGITS; i++) begin
      if (digit_nx == 3'(i)) nib = value[4*i +: 4];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_cnt <= '0;
      digit   <= 3'd0;
      an      <= ~(DIGITS'(1));
      seg     <= 7'b1000000;
    end else begin
      ref_cnt <= (ref_cnt == REFRESH_LAST) ? '0 : ref_cnt + RW'(1);
      digit   <= digit_nx;
      an      <= ~(DIGITS'(1) << digit_nx);
      seg     <= hex7(nib);
    end
  end

endmodule
